// File: rtl/ita_oup_stream_buffer_pkg.sv
// Shared constants, types and helpers for the ITA output stream buffer.
// Defaults describe the standard 16-lane, 8-bit output port configuration.
package ita_package;

  localparam int unsigned OupLanes      = 16;
  localparam int unsigned OupLaneWidth  = 8;
  localparam int unsigned OupBufDepth   = 8;
  localparam int unsigned OupBeatDiv    = 1;
  localparam int unsigned OupAlmostFull = 6;

  localparam int unsigned OupUsageWidth = $clog2(OupBufDepth + 1);
  localparam int unsigned OupBeatWidth  = (OupBeatDiv > 1) ? $clog2(OupBeatDiv) : 1;

  typedef logic [OupUsageWidth-1:0] oup_buf_usage_t;
  typedef logic [OupBeatWidth-1:0]  oup_beat_t;

  // Modulo increment that also works for depths that are not a power of two.
  function automatic int unsigned wrap_inc(int unsigned ptr, int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ita_oup_stream_buffer_if.sv
// Row-in / beat-out stream bundle of the ITA output buffer, plus its status.
// Signal names keep the buffer's point of view (_i into the buffer, _o out).
interface ita_oup_stream_buffer_if
  import ita_package::*;
#(
  parameter int unsigned N        = OupLanes,
  parameter int unsigned WI       = OupLaneWidth,
  parameter int unsigned DEPTH    = OupBufDepth,
  parameter int unsigned BEAT_DIV = OupBeatDiv
);

  localparam int unsigned UW = $clog2(DEPTH + 1);
  localparam int unsigned BW = (N / BEAT_DIV) * WI;

  logic          flush_i;
  logic          clear_max_i;
  logic          inp_valid_i;
  logic          inp_ready_o;
  logic [N*WI-1:0] inp_i;
  logic          oup_valid_o;
  logic          oup_ready_i;
  logic [BW-1:0] oup_o;
  logic          oup_last_o;
  logic          almost_full_o;
  logic [UW-1:0] usage_o;
  logic [UW-1:0] max_usage_o;

  modport slave (
    input  flush_i, clear_max_i, inp_valid_i, inp_i, oup_ready_i,
    output inp_ready_o, oup_valid_o, oup_o, oup_last_o, almost_full_o, usage_o, max_usage_o
  );

  modport master (
    output flush_i, clear_max_i, inp_valid_i, inp_i, oup_ready_i,
    input  inp_ready_o, oup_valid_o, oup_o, oup_last_o, almost_full_o, usage_o, max_usage_o
  );

endinterface

// File: rtl/ita_oup_stream_buffer_beat_mux.sv
// Selects the lane slice of a stored row that belongs to a given output beat.
module ita_oup_beat_mux #(
  parameter int unsigned N        = 16,
  parameter int unsigned WI       = 8,
  parameter int unsigned BEAT_DIV = 1
) (
  input  logic [N*WI-1:0]                                  row_i,
  input  logic [((BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1)-1:0] beat_i,
  output logic [(N/BEAT_DIV)*WI-1:0]                       beat_o
);

  localparam int unsigned BW = (N / BEAT_DIV) * WI;

  always_comb begin
    beat_o = row_i[32'(beat_i) * BW +: BW];
  end

endmodule

// File: rtl/ita_oup_stream_buffer.sv
// Output row FIFO between requantizer and ITA output port; each row leaves
// as BEAT_DIV narrow beats, lane 0 first.
module ita_oup_stream_buffer
  import ita_package::*;
#(
  parameter int unsigned N           = OupLanes,
  parameter int unsigned WI          = OupLaneWidth,
  parameter int unsigned DEPTH       = OupBufDepth,
  parameter int unsigned BEAT_DIV    = OupBeatDiv,
  parameter int unsigned ALMOST_FULL = OupAlmostFull
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  ita_oup_stream_buffer_if.slave  bus
);

  localparam int unsigned RW = N * WI;
  localparam int unsigned BW = (N / BEAT_DIV) * WI;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned UW = $clog2(DEPTH + 1);
  localparam int unsigned CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [UW-1:0] usage_t;
  typedef logic [CW-1:0] beat_t;

  logic [RW-1:0] mem_q [DEPTH];
  ptr_t          wr_ptr_q, rd_ptr_q;
  usage_t        usage_q, usage_d, max_q;
  beat_t         beat_q;

  logic          empty, full, inp_ready;
  logic          push, beat_hs, beat_last, pop;
  logic [BW-1:0] beat_data;

  assign empty     = (usage_q == '0);
  assign full      = (usage_q == usage_t'(DEPTH));
  // Ready depends only on occupancy and flush, never on the output side.
  assign inp_ready = !full && !bus.flush_i;
  assign push      = bus.inp_valid_i && inp_ready;
  assign beat_last = (beat_q == beat_t'(BEAT_DIV - 1));
  assign beat_hs   = !empty && bus.oup_ready_i;
  assign pop       = beat_hs && beat_last;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    usage_d = usage_q;
    if (bus.flush_i)       usage_d = '0;
    else if (push && !pop) usage_d = usage_q + usage_t'(1);
    else if (pop && !push) usage_d = usage_q - usage_t'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      usage_q  <= '0;
      max_q    <= '0;
    end else begin
      usage_q <= usage_d;
      max_q   <= (bus.clear_max_i || usage_d > max_q) ? usage_d : max_q;
      if (bus.flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        beat_q   <= '0;
      end else begin
        if (push)    wr_ptr_q <= ptr_t'(wrap_inc(32'(wr_ptr_q), DEPTH));
        if (pop)     rd_ptr_q <= ptr_t'(wrap_inc(32'(rd_ptr_q), DEPTH));
        if (beat_hs) beat_q   <= beat_last ? '0 : beat_q + beat_t'(1);
      end
    end
  end

  // NOTE: row storage is deliberately not reset; an entry is only ever read after it was written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.inp_i;
  end

  ita_oup_beat_mux #(
    .N        (N),
    .WI       (WI),
    .BEAT_DIV (BEAT_DIV)
  ) i_beat_mux (
    .row_i  (mem_q[rd_ptr_q]),
    .beat_i (beat_q),
    .beat_o (beat_data)
  );

  assign bus.inp_ready_o   = inp_ready;
  assign bus.oup_valid_o   = !empty;
  assign bus.oup_o         = empty ? '0 : beat_data;
  assign bus.oup_last_o    = !empty && beat_last;
  assign bus.almost_full_o = (usage_q >= usage_t'(ALMOST_FULL));
  assign bus.usage_o       = usage_q;
  assign bus.max_usage_o   = max_q;

  a_push_needs_ready : assert property (
    @(posedge clk_i) disable iff (!rst_ni) push |-> inp_ready);

  a_oup_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      (bus.oup_valid_o && !bus.oup_ready_i && !bus.flush_i) |=> $stable(bus.oup_o));

endmodule
